// File: rtl/hqm_aw_fifo_push_db_wctl.sv
// rtl/hqm_aw_fifo_push_db_wctl.sv - push-side double-buffered FIFO write controller
//
// Purpose:
//   Accepts a valid/ready stream into a 2-entry input double buffer, drains the
//   buffer head into a FIFO memory write port, and tracks FIFO occupancy from
//   credit pulses returned by the reader.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cfg_high_wm         almost-full watermark (compared against depth)
//   i_fifo_enable         gates draining into memory; acceptance unaffected
//   i_clear_push_state    synchronous clear of all state, highest priority
//   i_in_valid/i_in_data  upstream beat
//   o_in_ready            upstream ready, registered
//   i_pop_credit          one-cycle pulse: reader consumed one entry
//   o_mem_we/_waddr/_wdata memory write port
//   o_fifo_depth          FIFO occupancy
//   o_fifo_full/_afull/_empty  status flags from the registered depth
//   o_db_status           {err_underflow, in_ready, db_count[1:0]}

module hqm_aw_fifo_push_db_wctl #(
    parameter int DEPTH      = 8,
    parameter int DWIDTH     = 32,
    // Equivalent to floor(log2(DEPTH-1))+1 for every DEPTH >= 2.
    parameter int AWIDTH     = $clog2(DEPTH),
    parameter int DEPTHWIDTH = ((2 ** AWIDTH) == DEPTH) ? AWIDTH + 1 : AWIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DEPTHWIDTH-1:0] i_cfg_high_wm,
    input  logic                  i_fifo_enable,
    input  logic                  i_clear_push_state,
    input  logic                  i_in_valid,
    input  logic [DWIDTH-1:0]     i_in_data,
    output logic                  o_in_ready,
    input  logic                  i_pop_credit,
    output logic                  o_mem_we,
    output logic [AWIDTH-1:0]     o_mem_waddr,
    output logic [DWIDTH-1:0]     o_mem_wdata,
    output logic [DEPTHWIDTH-1:0] o_fifo_depth,
    output logic                  o_fifo_full,
    output logic                  o_fifo_afull,
    output logic                  o_fifo_empty,
    output logic [3:0]            o_db_status
);

    // Double buffer: entry 0 is the head (oldest beat).
    logic [DWIDTH-1:0]     r_db_data [2];
    logic [1:0]            r_db_count;
    logic                  r_in_ready;
    logic [AWIDTH-1:0]     r_wptr;
    logic [DEPTHWIDTH-1:0] r_depth;
    logic                  r_err_underflow;
    // Last driven write address/data, so the port holds while idle.
    logic [AWIDTH-1:0]     r_hold_waddr;
    logic [DWIDTH-1:0]     r_hold_wdata;

    logic                  w_accept;
    logic                  w_drain;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_credit_ok;
    logic                  w_wr_idx;
    logic [1:0]            w_db_count_nxt;
    logic [DEPTHWIDTH-1:0] w_depth_nxt;
    logic [AWIDTH-1:0]     w_wptr_nxt;

    always_comb begin
        w_full      = (r_depth == DEPTHWIDTH'(DEPTH));
        w_empty     = (r_depth == '0);
        w_accept    = i_in_valid & r_in_ready;
        // Full comes from the registered depth, so a credit arriving while
        // full cannot enable a write in the same cycle.
        w_drain     = (r_db_count != 2'd0) & ~w_full & i_fifo_enable & ~i_clear_push_state;
        w_credit_ok = i_pop_credit & ~w_empty;
        w_db_count_nxt = r_db_count + 2'(w_accept) - 2'(w_drain);
        // Tail slot after an optional shift: accept only happens with
        // count <= 1, so the slot is 1 only when one entry stays put.
        w_wr_idx    = r_db_count[0] & ~w_drain;
        w_depth_nxt = r_depth + DEPTHWIDTH'(w_drain) - DEPTHWIDTH'(w_credit_ok);
        // Explicit wrap so non power-of-2 depths work.
        w_wptr_nxt  = (r_wptr == AWIDTH'(DEPTH - 1)) ? '0 : r_wptr + AWIDTH'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_count      <= '0;
            r_in_ready      <= 1'b1;
            r_wptr          <= '0;
            r_depth         <= '0;
            r_err_underflow <= 1'b0;
            r_hold_waddr    <= '0;
            r_hold_wdata    <= '0;
        end else if (i_clear_push_state) begin
            r_db_count      <= '0;
            r_in_ready      <= 1'b1;
            r_wptr          <= '0;
            r_depth         <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_db_count <= w_db_count_nxt;
            r_in_ready <= (w_db_count_nxt < 2'd2);
            r_depth    <= w_depth_nxt;
            if (w_drain) begin
                r_wptr       <= w_wptr_nxt;
                r_hold_waddr <= r_wptr;
                r_hold_wdata <= r_db_data[0];
            end
            if (i_pop_credit & w_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // Buffer payload needs no reset; validity is tracked by r_db_count.
    always_ff @(posedge i_clk) begin
        if (!i_clear_push_state) begin
            if (w_drain) begin
                r_db_data[0] <= r_db_data[1];
            end
            if (w_accept) begin
                r_db_data[w_wr_idx] <= i_in_data;
            end
        end
    end

    // Write data and address come only from flops; only the enable/clear
    // controls gate the strobe combinationally.
    assign o_mem_we     = w_drain;
    assign o_mem_waddr  = w_drain ? r_wptr : r_hold_waddr;
    assign o_mem_wdata  = w_drain ? r_db_data[0] : r_hold_wdata;
    assign o_in_ready   = r_in_ready;
    assign o_fifo_depth = r_depth;
    assign o_fifo_full  = w_full;
    assign o_fifo_afull = (r_depth >= i_cfg_high_wm);
    assign o_fifo_empty = w_empty;
    assign o_db_status  = {r_err_underflow, r_in_ready, r_db_count};

endmodule

// File: tb/tb_hqm_aw_fifo_push_db_wctl.sv
// tb/tb_hqm_aw_fifo_push_db_wctl.sv - self-checking bench for the push-side FIFO write controller
module tb_hqm_aw_fifo_push_db_wctl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // DEPTH=8 instance
    logic [3:0]  cfg8;
    logic        en8, clr8, v8, rdy8, pc8, we8, full8, afull8, empty8;
    logic [31:0] d8, wd8;
    logic [2:0]  wa8;
    logic [3:0]  dep8, st8;

    // DEPTH=6 instance
    logic [2:0]  cfg6;
    logic        en6, clr6, v6, rdy6, pc6, we6, full6, afull6, empty6;
    logic [31:0] d6, wd6;
    logic [2:0]  wa6;
    logic [2:0]  dep6;
    logic [3:0]  st6;

    hqm_aw_fifo_push_db_wctl #(.DEPTH(8), .DWIDTH(32)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_cfg_high_wm(cfg8), .i_fifo_enable(en8),
        .i_clear_push_state(clr8), .i_in_valid(v8), .i_in_data(d8), .o_in_ready(rdy8),
        .i_pop_credit(pc8), .o_mem_we(we8), .o_mem_waddr(wa8), .o_mem_wdata(wd8),
        .o_fifo_depth(dep8), .o_fifo_full(full8), .o_fifo_afull(afull8),
        .o_fifo_empty(empty8), .o_db_status(st8)
    );

    hqm_aw_fifo_push_db_wctl #(.DEPTH(6), .DWIDTH(32)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_cfg_high_wm(cfg6), .i_fifo_enable(en6),
        .i_clear_push_state(clr6), .i_in_valid(v6), .i_in_data(d6), .o_in_ready(rdy6),
        .i_pop_credit(pc6), .o_mem_we(we6), .o_mem_waddr(wa6), .o_mem_wdata(wd6),
        .o_fifo_depth(dep6), .o_fifo_full(full6), .o_fifo_afull(afull6),
        .o_fifo_empty(empty6), .o_db_status(st6)
    );

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] wm;
        logic       exp_afull;
    } wm_vec_t;

    exp_t q8[$];
    exp_t q6[$];
    int   wp8 = 0;
    int   wp6 = 0;
    int   wr8 = 0;
    int   wr6 = 0;
    int   wcyc8[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q8.delete();
        q6.delete();
        wp8 = 0;
        wp6 = 0;
    endtask

    // Presents one beat for one cycle; scoreboard entry pushed if it is taken.
    task automatic offer8(input logic [31:0] data, output bit acc);
        v8  = 1'b1;
        d8  = data;
        acc = (rdy8 === 1'b1);
        if (acc) begin
            q8.push_back('{addr: 3'(wp8), data: data});
            wp8 = (wp8 + 1) % 8;
        end
        step();
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst === 1'b0 && we8 === 1'b1) begin
            wr8++;
            wcyc8.push_back(cyc_n);
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL wr8_unexpected: got addr %0d data %0h expected no write", wa8, wd8);
            end else begin
                e = q8.pop_front();
                if (wa8 !== e.addr || wd8 !== e.data) begin
                    bad++;
                    $display("FAIL wr8: got addr %0d data %0h expected addr %0d data %0h",
                             wa8, wd8, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon6
        exp_t e;
        if (rst === 1'b0 && we6 === 1'b1) begin
            wr6++;
            total++;
            if (q6.size() == 0) begin
                bad++;
                $display("FAIL wr6_unexpected: got addr %0d data %0h expected no write", wa6, wd6);
            end else begin
                e = q6.pop_front();
                if (wa6 !== e.addr || wd6 !== e.data) begin
                    bad++;
                    $display("FAIL wr6: got addr %0d data %0h expected addr %0d data %0h",
                             wa6, wd6, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wm_vec_t wm_tab[6];
        bit      a;
        int      n_acc;
        int      acc_cyc;
        int      wr_before;
        int      en_cyc;
        int      acc3_cyc;
        int      max6;
        int      n6;

        wm_tab[0] = '{wm: 4'd0,  exp_afull: 1'b1};
        wm_tab[1] = '{wm: 4'd3,  exp_afull: 1'b1};
        wm_tab[2] = '{wm: 4'd4,  exp_afull: 1'b1};
        wm_tab[3] = '{wm: 4'd5,  exp_afull: 1'b0};
        wm_tab[4] = '{wm: 4'd8,  exp_afull: 1'b0};
        wm_tab[5] = '{wm: 4'd15, exp_afull: 1'b0};

        rst = 1'b1;
        cfg8 = 4'd3; en8 = 1'b0; clr8 = 1'b0; v8 = 1'b0; d8 = '0; pc8 = 1'b0;
        cfg6 = 3'd6; en6 = 1'b0; clr6 = 1'b0; v6 = 1'b0; d6 = '0; pc6 = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_depth", dep8, 0);
        chk("rst_empty", empty8, 1);
        chk("rst_full", full8, 0);
        chk("rst_afull_wm3", afull8, 0);
        chk("rst_ready", rdy8, 1);
        chk("rst_we", we8, 0);
        chk("rst_waddr", wa8, 0);
        chk("rst_wdata", wd8, 0);
        chk("rst_status", st8, 4'b0100);
        cfg8 = 4'd0;
        #1;
        chk("rst_afull_wm0", afull8, 1);
        cfg8 = 4'd7;
        rst = 1'b0;
        step();

        // Three back-to-back beats, continuous drain
        en8 = 1'b1;
        step();
        acc_cyc = cyc_n;
        for (int i = 0; i < 3; i++) begin
            chk("s1_ready", rdy8, 1);
            offer8(32'hA000_0000 + 32'(i), a);
        end
        v8 = 1'b0;
        repeat (4) step();
        chk("s1_writes", wr8, 3);
        chk("s1_first_lat", wcyc8[0], acc_cyc + 1);
        chk("s1_consecutive", wcyc8[2] - wcyc8[0], 2);
        chk("s1_depth", dep8, 3);
        chk("s1_sb_empty", q8.size(), 0);

        // Fill to full, buffer backs up, ready drops
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            offer8(32'h2000 + 32'(n_acc), a);
            if (a) n_acc++;
        end
        v8 = 1'b0;
        step();
        chk("s2_accepted", n_acc, 7);
        chk("s2_depth", dep8, 8);
        chk("s2_full", full8, 1);
        chk("s2_dbcount", st8[1:0], 2);
        chk("s2_ready", rdy8, 0);
        chk("s2_writes", wr8, 8);
        // One credit lets exactly one write through (wraps to address 0)
        pc8 = 1'b1;
        step();
        pc8 = 1'b0;
        repeat (4) step();
        chk("s2_credit_writes", wr8, 9);
        chk("s2_credit_depth", dep8, 8);
        chk("s2_credit_ready", rdy8, 1);
        chk("s2_credit_dbcount", st8[1:0], 1);
        chk("s2_sb_left", q8.size(), 1);

        clr8 = 1'b1;
        flush();
        step();
        clr8 = 1'b0;
        chk("clr_depth", dep8, 0);
        chk("clr_status", st8, 4'b0100);
        chk("clr_empty", empty8, 1);

        // Underflow is sticky until clear
        pc8 = 1'b1;
        step();
        pc8 = 1'b0;
        chk("uf_depth", dep8, 0);
        chk("uf_flag", st8[3], 1);
        step();
        chk("uf_sticky", st8[3], 1);
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
        chk("uf_clr_flag", st8[3], 0);
        chk("uf_clr_ready", rdy8, 1);

        // Watermark
        cfg8 = 4'd4;
        for (int i = 0; i < 4; i++) offer8(32'h5000 + 32'(i), a);
        v8 = 1'b0;
        repeat (3) step();
        chk("wm_depth4", dep8, 4);
        chk("wm_afull4", afull8, 1);
        for (int i = 0; i < 6; i++) begin
            cfg8 = wm_tab[i].wm;
            #1;
            chk($sformatf("wm_tab%0d", i), afull8, wm_tab[i].exp_afull);
        end
        cfg8 = 4'd4;
        #1;
        pc8 = 1'b1;
        step();
        pc8 = 1'b0;
        chk("wm_credit_depth", dep8, 3);
        chk("wm_credit_afull", afull8, 0);
        offer8(32'h5004, a);
        v8 = 1'b0;
        repeat (2) step();
        chk("wm_refill_depth", dep8, 4);
        chk("wm_refill_afull", afull8, 1);
        wr_before = wr8;
        offer8(32'h5005, a);
        v8  = 1'b0;
        pc8 = 1'b1;
        step();
        pc8 = 1'b0;
        chk("wc_depth", dep8, 4);
        step();
        chk("wc_depth_hold", dep8, 4);
        chk("wc_writes", wr8, wr_before + 1);
        chk("wc_sb_empty", q8.size(), 0);

        // Drain disabled: buffer fills, ready drops, no writes
        clr8 = 1'b1;
        flush();
        step();
        clr8 = 1'b0;
        en8 = 1'b0;
        wr_before = wr8;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            offer8(32'h6000 + 32'(n_acc), a);
            if (a) n_acc++;
        end
        chk("dis_accepted", n_acc, 2);
        chk("dis_ready", rdy8, 0);
        chk("dis_writes", wr8, wr_before);
        en8 = 1'b1;
        en_cyc = cyc_n;
        acc3_cyc = -1;
        for (int i = 0; i < 10 && n_acc < 3; i++) begin
            acc3_cyc = cyc_n;
            offer8(32'h6000 + 32'(n_acc), a);
            if (a) n_acc++;
        end
        v8 = 1'b0;
        repeat (3) step();
        chk("en_accepted", n_acc, 3);
        chk("en_acc3_cycle", acc3_cyc, en_cyc + 1);
        chk("en_writes", wr8, wr_before + 3);

        // DEPTH=6 wrap with lagging credits
        en6 = 1'b1;
        step();
        max6 = 0;
        n6 = 0;
        for (int i = 0; i < 18; i++) begin
            v6  = (i < 14);
            d6  = 32'h3000 + 32'(i);
            pc6 = (i >= 4);
            if (v6 && rdy6 === 1'b1) begin
                q6.push_back('{addr: 3'(wp6), data: d6});
                wp6 = (wp6 + 1) % 6;
                n6++;
            end
            if (int'(dep6) > max6) max6 = int'(dep6);
            step();
        end
        v6 = 1'b0;
        pc6 = 1'b0;
        repeat (2) step();
        chk("d6_accepted", n6, 14);
        chk("d6_writes", wr6, 14);
        chk("d6_depth", dep6, 0);
        chk("d6_max_le6", (max6 <= 6), 1);
        chk("d6_no_uf", st6[3], 0);
        chk("d6_sb_empty", q6.size(), 0);

        // Reset mid-stream
        offer8(32'h7000, a);
        offer8(32'h7001, a);
        rst = 1'b1;
        flush();
        #1;
        chk("mrst_depth", dep8, 0);
        chk("mrst_ready", rdy8, 1);
        chk("mrst_we", we8, 0);
        v8 = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
